// File: rtl/cpc_ramcfg_pkg.sv
// cpc_ramcfg_pkg
// Shared definitions for the CPC 1MB RAM configuration capture front end:
// FSM state encoding, the config-port select pattern, the bit positions of
// the captured fields inside the config byte, and the port-match helper.
package cpc_ramcfg_pkg;

  // Capture FSM states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    QUAL    = 3'd1,
    ARMED   = 3'd2,
    COMMIT  = 3'd3,
    WAIT_HI = 3'd4
  } cfg_state_e;

  // D7:D6 pattern that selects the RAM configuration register
  localparam logic [1:0] CFG_SEL_HI = 2'b11;

  // Field positions inside the config byte
  localparam int RAMBLOCK_LSB = 0;
  localparam int RAMBLOCK_MSB = 2;
  localparam int ADRHI_LSB    = 3;
  localparam int ADRHI_MSB    = 5;

  // True when an I/O write targets the RAM configuration port
  function automatic logic cfg_match(input logic a15, input logic [7:0] d);
    return (a15 == 1'b0) && (d[7:6] == CFG_SEL_HI);
  endfunction

endpackage

// File: rtl/cpc_sync_bit.sv
// cpc_sync_bit
// N-stage single-bit synchroniser with asynchronous active-low reset to a
// parameterised level.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset (all stages load RST_VAL)
//   din   - asynchronous input
//   dout  - synchronised output (last stage)
module cpc_sync_bit #(
  parameter int   N       = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic [N-1:0] stage_r;

  // Shift the asynchronous input through the synchroniser chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_r <= {N{RST_VAL}};
    end else begin
      stage_r <= {stage_r[N-2:0], din};
    end
  end

  assign dout = stage_r[N-1];

endmodule

// File: rtl/cpc_ramcfg_capture.sv
// cpc_ramcfg_capture
// Clocked front end for the 1MB RAM expansion decode. Watches Z80 I/O
// write cycles, qualifies writes to the RAM configuration port
// (A15=0, D7:D6=11) and, when the write strobe is released, presents the
// captured fields to the downstream chip-select / RAMDIS decoder.
// Ports:
//   CLK        - board clock, >= 4x Z80 clock
//   RESET_B    - asynchronous active-low reset
//   IOREQ_B    - Z80 I/O request (async)
//   WR_B       - Z80 write strobe (async)
//   A15, A8    - address bits; A8 selects the 512K SRAM
//   D          - Z80 data bus
//   ramblock   - config D2:D0
//   ramadrhi   - config D5:D3 in bits 4:2, bits 1:0 zero
//   bank_sel   - latched A8
//   cfg_strobe - one-cycle pulse per commit
//   cfg_count  - committed-write counter, wraps
module cpc_ramcfg_capture
  import cpc_ramcfg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_LOW     = 3,
  parameter int CNT_W       = 8
) (
  input  logic             CLK,
  input  logic             RESET_B,
  input  logic             IOREQ_B,
  input  logic             WR_B,
  input  logic             A15,
  input  logic             A8,
  input  logic [7:0]       D,
  output logic [2:0]       ramblock,
  output logic [4:0]       ramadrhi,
  output logic             bank_sel,
  output logic             cfg_strobe,
  output logic [CNT_W-1:0] cfg_count
);

  localparam int QW = $clog2(MIN_LOW + 1);
  localparam int SW = $clog2(SYNC_STAGES + 1);
  localparam logic [QW-1:0] QMAX      = QW'(MIN_LOW);
  localparam logic [QW-1:0] QONE      = QW'(1);
  localparam logic [SW-1:0] SETTLE    = SW'(SYNC_STAGES);
  localparam logic [SW-1:0] SONE      = SW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic       iorq_sync_s;
  logic       wr_sync_s;
  logic       io_wr_s;

  cfg_state_e state_r;
  cfg_state_e state_nxt_s;
  logic [QW-1:0] qcnt_r;
  logic [SW-1:0] settle_r;
  logic       seen_hi_r;

  logic       qual_start_s;
  logic       qual_inc_s;
  logic       load_shadow_s;
  logic       commit_s;

  logic [2:0] shadow_block_r;
  logic [2:0] shadow_adrhi_r;
  logic       shadow_bank_r;

  cpc_sync_bit #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_iorq (
    .clk   (CLK),
    .rst_n (RESET_B),
    .din   (IOREQ_B),
    .dout  (iorq_sync_s)
  );

  cpc_sync_bit #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_wr (
    .clk   (CLK),
    .rst_n (RESET_B),
    .din   (WR_B),
    .dout  (wr_sync_s)
  );

  assign io_wr_s = ~iorq_sync_s & ~wr_sync_s;

  // Next-state decode and per-cycle action strobes
  always_comb begin
    state_nxt_s   = state_r;
    qual_start_s  = 1'b0;
    qual_inc_s    = 1'b0;
    load_shadow_s = 1'b0;
    commit_s      = 1'b0;
    case (state_r)
      IDLE: begin
        // seen_hi_r blocks a strobe that was already low at reset release
        if (io_wr_s && seen_hi_r) begin
          state_nxt_s  = QUAL;
          qual_start_s = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      QUAL: begin
        if (!io_wr_s) begin
          state_nxt_s = IDLE;
        end else if (qcnt_r < QMAX) begin
          qual_inc_s = 1'b1;
        end else if (cfg_match(A15, D)) begin
          load_shadow_s = 1'b1;
          state_nxt_s   = ARMED;
        end else begin
          state_nxt_s = WAIT_HI;
        end
      end
      ARMED: begin
        // Commit on release so the decoder never sees a mid-write change
        if (!io_wr_s) begin
          commit_s    = 1'b1;
          state_nxt_s = COMMIT;
        end else begin
          state_nxt_s = ARMED;
        end
      end
      COMMIT: begin
        state_nxt_s = IDLE;
      end
      WAIT_HI: begin
        if (!io_wr_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_HI;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM, qualification counter and reset-settle tracking
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      state_r   <= IDLE;
      qcnt_r    <= '0;
      settle_r  <= '0;
      seen_hi_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (qual_start_s) begin
        qcnt_r <= QONE;
      end else if (qual_inc_s) begin
        qcnt_r <= qcnt_r + QONE;
      end else begin
        qcnt_r <= qcnt_r;
      end
      // The synchroniser output only reflects the pins once the preset
      // values have been flushed out of every stage.
      if (settle_r != SETTLE) begin
        settle_r <= settle_r + SONE;
      end else begin
        settle_r <= settle_r;
      end
      if ((settle_r == SETTLE) && !io_wr_s) begin
        seen_hi_r <= 1'b1;
      end else begin
        seen_hi_r <= seen_hi_r;
      end
    end
  end

  // Shadow capture of the qualification-cycle sample
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      shadow_block_r <= 3'd0;
      shadow_adrhi_r <= 3'd0;
      shadow_bank_r  <= 1'b0;
    end else if (load_shadow_s) begin
      shadow_block_r <= D[RAMBLOCK_MSB:RAMBLOCK_LSB];
      shadow_adrhi_r <= D[ADRHI_MSB:ADRHI_LSB];
      shadow_bank_r  <= A8;
    end else begin
      shadow_block_r <= shadow_block_r;
      shadow_adrhi_r <= shadow_adrhi_r;
      shadow_bank_r  <= shadow_bank_r;
    end
  end

  // Registered outputs, loaded on the edge that enters COMMIT
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      ramblock   <= 3'd0;
      ramadrhi   <= 5'd0;
      bank_sel   <= 1'b0;
      cfg_strobe <= 1'b0;
      cfg_count  <= '0;
    end else begin
      cfg_strobe <= commit_s;
      if (commit_s) begin
        ramblock  <= shadow_block_r;
        ramadrhi  <= {shadow_adrhi_r, 2'b00};
        bank_sel  <= shadow_bank_r;
        cfg_count <= cfg_count + CNT_ONE;
      end else begin
        ramblock  <= ramblock;
        ramadrhi  <= ramadrhi;
        bank_sel  <= bank_sel;
        cfg_count <= cfg_count;
      end
    end
  end

endmodule

// File: tb/tb_cpc_ramcfg_capture.sv
// Self-checking bench for cpc_ramcfg_capture: latency sequence, a table of
// directed vectors, hand-written multi-cycle corner cases, and randomized
// writes checked against a transaction-level model.
module tb_cpc_ramcfg_capture;

  localparam int SYNC_STAGES = 2;
  localparam int MIN_LOW     = 3;
  localparam int CNT_W       = 8;

  logic             CLK = 1'b0;
  logic             RESET_B = 1'b0;
  logic             IOREQ_B = 1'b1;
  logic             WR_B = 1'b1;
  logic             A15 = 1'b0;
  logic             A8 = 1'b0;
  logic [7:0]       D = 8'h00;
  logic [2:0]       ramblock;
  logic [4:0]       ramadrhi;
  logic             bank_sel;
  logic             cfg_strobe;
  logic [CNT_W-1:0] cfg_count;

  int n_vec  = 0;
  int n_fail = 0;
  int strobe_cnt = 0;

  cpc_ramcfg_capture #(
    .SYNC_STAGES(SYNC_STAGES), .MIN_LOW(MIN_LOW), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .RESET_B(RESET_B), .IOREQ_B(IOREQ_B), .WR_B(WR_B),
    .A15(A15), .A8(A8), .D(D),
    .ramblock(ramblock), .ramadrhi(ramadrhi), .bank_sel(bank_sel),
    .cfg_strobe(cfg_strobe), .cfg_count(cfg_count)
  );

  always #5 CLK = ~CLK;

  // Count strobe-high cycles; equals commit count only if pulses are 1 cycle
  always @(negedge CLK) begin
    if (cfg_strobe === 1'b1) strobe_cnt++;
  end

  typedef struct {
    logic       a15;
    logic       a8;
    logic [7:0] d;
    int         low;
    logic [2:0] rb;
    logic [4:0] adr;
    logic       bank;
    logic [7:0] cnt;
    int         strobes;
  } vec_t;

  vec_t tbl[7];

  // Model state
  logic [2:0] m_rb;
  logic [4:0] m_adr;
  logic       m_bank;
  logic [7:0] m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one I/O write: pins low for 'low' CLK cycles, optional data
  // change in the 8th cycle, then release and idle long enough to commit.
  task automatic do_write(input logic a15, input logic a8, input logic [7:0] d,
                          input int low, input logic late_en, input logic [7:0] d_late);
    @(negedge CLK);
    A15 = a15; A8 = a8; D = d; IOREQ_B = 1'b0; WR_B = 1'b0;
    for (int i = 1; i <= low; i++) begin
      @(negedge CLK);
      if (late_en && i == 8) D = d_late;
    end
    IOREQ_B = 1'b1; WR_B = 1'b1;
    repeat (8) @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET_B = 1'b0;
    IOREQ_B = 1'b1; WR_B = 1'b1;
    repeat (3) @(negedge CLK);
    RESET_B = 1'b1;
    repeat (4) @(negedge CLK);
    m_rb = 3'd0; m_adr = 5'd0; m_bank = 1'b0; m_cnt = 8'd0;
  endtask

  // Transaction-level model: a write commits if the strobe stayed low long
  // enough and the port matches; the fields come from the initial bus value.
  task automatic model_write(input logic a15, input logic a8, input logic [7:0] d, input int low);
    if (low > MIN_LOW && a15 == 1'b0 && d[7:6] == 2'b11) begin
      m_rb   = d[2:0];
      m_adr  = {d[5:3], 2'b00};
      m_bank = a8;
      m_cnt  = m_cnt + 8'd1;
    end
  endtask

  function automatic logic [31:0] outs();
    return {15'd0, ramblock, ramadrhi, bank_sel, cfg_count};
  endfunction

  function automatic logic [31:0] mexp();
    return {15'd0, m_rb, m_adr, m_bank, m_cnt};
  endfunction

  initial begin
    int s0;
    logic [7:0] d;
    logic a15, a8;
    int low;

    tbl[0] = '{1'b0, 1'b0, 8'hDF, 10, 3'd7, 5'b01100, 1'b0, 8'd2, 1};
    tbl[1] = '{1'b0, 1'b1, 8'h8C, 10, 3'd7, 5'b01100, 1'b0, 8'd2, 0};
    tbl[2] = '{1'b0, 1'b1, 8'hC7,  2, 3'd7, 5'b01100, 1'b0, 8'd2, 0};
    tbl[3] = '{1'b0, 1'b1, 8'hC7, 10, 3'd7, 5'b00000, 1'b1, 8'd3, 1};
    tbl[4] = '{1'b1, 1'b0, 8'hE2, 10, 3'd7, 5'b00000, 1'b1, 8'd3, 0};
    tbl[5] = '{1'b0, 1'b0, 8'h7A, 10, 3'd7, 5'b00000, 1'b1, 8'd3, 0};
    tbl[6] = '{1'b0, 1'b0, 8'hF3, 10, 3'd3, 5'b11000, 1'b0, 8'd4, 1};

    // Reset state, including the asynchronous effect
    #2;
    check("reset_outputs", {outs(), 31'd0, cfg_strobe}, 32'd0);
    do_reset();
    check("post_reset_outputs", {outs(), 31'd0, cfg_strobe}, 32'd0);

    // OUT &7F,&C5 with cycle-accurate latency check
    s0 = strobe_cnt;
    @(negedge CLK);
    A15 = 1'b0; A8 = 1'b1; D = 8'hC5; IOREQ_B = 1'b0; WR_B = 1'b0;
    repeat (10) @(negedge CLK);
    IOREQ_B = 1'b1; WR_B = 1'b1;
    @(posedge CLK); #1;
    check("lat_edge1", {23'd0, cfg_strobe, cfg_count}, 32'd0);
    @(posedge CLK); #1;
    check("lat_edge2", {23'd0, cfg_strobe, cfg_count}, 32'd0);
    @(posedge CLK); #1;
    check("lat_edge3_strobe", {31'd0, cfg_strobe}, 32'd1);
    check("lat_edge3_outs", outs(), {15'd0, 3'd5, 5'b00000, 1'b1, 8'd1});
    @(posedge CLK); #1;
    check("lat_edge4_strobe", {31'd0, cfg_strobe}, 32'd0);
    repeat (4) @(negedge CLK);
    check("c5_strobe_count", strobe_cnt - s0, 32'd1);

    // Directed table
    for (int i = 0; i < 7; i++) begin
      s0 = strobe_cnt;
      do_write(tbl[i].a15, tbl[i].a8, tbl[i].d, tbl[i].low, 1'b0, 8'h00);
      check($sformatf("tbl%0d_outs", i), outs(),
            {15'd0, tbl[i].rb, tbl[i].adr, tbl[i].bank, tbl[i].cnt});
      check($sformatf("tbl%0d_strobes", i), strobe_cnt - s0, tbl[i].strobes);
    end

    // Bus change while ARMED: first sample wins
    do_write(1'b0, 1'b0, 8'hC1, 14, 1'b1, 8'hC3);
    check("armed_change", outs(), {15'd0, 3'd1, 5'b00000, 1'b0, 8'd5});

    // Reset while ARMED, released with strobe still low
    @(negedge CLK);
    A15 = 1'b0; A8 = 1'b1; D = 8'hC9; IOREQ_B = 1'b0; WR_B = 1'b0;
    repeat (8) @(negedge CLK);
    #2 RESET_B = 1'b0;
    #1;
    check("async_reset_outs", {outs(), 31'd0, cfg_strobe}, 32'd0);
    s0 = strobe_cnt;
    repeat (3) @(negedge CLK);
    RESET_B = 1'b1;
    repeat (12) @(negedge CLK);
    check("held_after_reset", {outs(), strobe_cnt - s0}, 32'd0);
    IOREQ_B = 1'b1; WR_B = 1'b1;
    repeat (8) @(negedge CLK);
    check("release_after_reset", {outs(), strobe_cnt - s0}, 32'd0);
    do_write(1'b0, 1'b1, 8'hC9, 10, 1'b0, 8'h00);
    check("fresh_write_after_reset", outs(), {15'd0, 3'd1, 5'b00100, 1'b1, 8'd1});

    // 256 consecutive matching writes from reset: counter wraps to 0
    do_reset();
    s0 = strobe_cnt;
    for (int k = 0; k < 256; k++) begin
      d = {2'b11, 6'($urandom)};
      a8 = 1'($urandom);
      low = $urandom_range(MIN_LOW + 2, 12);
      do_write(1'b0, a8, d, low, (low >= 10), 8'($urandom));
      model_write(1'b0, a8, d, low);
      if (k == 254) check("wrap_255", {24'd0, cfg_count}, 32'd255);
    end
    check("wrap_count_zero", {24'd0, cfg_count}, 32'd0);
    check("wrap_strobes", strobe_cnt - s0, 32'd256);
    check("wrap_fields", outs(), mexp());

    // Randomized mixed traffic against the model
    for (int k = 0; k < 40; k++) begin
      a15 = ($urandom_range(0, 3) == 0);
      a8  = 1'($urandom);
      d   = 8'($urandom);
      if ($urandom_range(0, 2) != 0) d[7:6] = 2'b11;
      if ($urandom_range(0, 3) == 0) low = $urandom_range(1, MIN_LOW - 1);
      else low = $urandom_range(MIN_LOW + 2, 12);
      s0 = strobe_cnt;
      do_write(a15, a8, d, low, (low >= 10), 8'($urandom));
      begin
        logic [7:0] c_before;
        c_before = m_cnt;
        model_write(a15, a8, d, low);
        check($sformatf("rnd%0d_outs", k), outs(), mexp());
        check($sformatf("rnd%0d_strobes", k), strobe_cnt - s0, {24'd0, m_cnt - c_before});
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
